mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  MEM pipeline stage, directly downstream of EX. Consumes ex_mem_cword, runs
//  load/store over a req/ack data-memory port, aligns/extends load data into
//  rd_data, emits mem_wb_cword to WB. Raises mem_stall for the whole pipeline
//  while an access is outstanding.
// PARAMETERS
//  DMEM_TIMEOUT  64  max BUSY cycles without dmem_ack before fault; 0 = no timeout
//  (XLEN = 32, byte-addressed, little-endian, from rvga_params.vh)
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      reset, synchronous, active-low
//  stall         in   1      global pipeline stall (includes mem_stall via hazard unit)
//  ex_mem_cword  in   cword  from EX; fields used: mem_read, mem_write, funct3, rd_data (addr), rs2_data
//  mem_wb_cword  out  cword  to WB; copy of ex_mem_cword, rd_data replaced on loads
//  mem_stall     out  1      combinational: access in flight or not yet completed
//  mem_fault     out  1      registered alongside mem_wb_cword; misaligned/illegal/timeout
//  dmem_req      out  1      registered request, held until ack or timeout
//  dmem_we       out  1      1 = store
//  dmem_addr     out  32     word-aligned address ({addr[31:2],2'b00})
//  dmem_be       out  4      byte enables (stores; 4'hF on loads)
//  dmem_wdata    out  32     lane-replicated store data
//  dmem_rdata    in   32     read data, valid with dmem_ack
//  dmem_ack      in   1      completion; meaningful only while dmem_req=1
// BEHAVIOUR
//  Reset: state IDLE; mem_wb_cword=0, mem_fault=0, dmem_req=0, dmem_we=0,
//   dmem_addr/be/wdata=0, timeout counter=0, load-data reg=0.
//  access = mem_read|mem_write. fault_now = misaligned (H: a[0]; W: a[1:0]!=0),
//   funct3 in {011,110,111}, or mem_read&mem_write. Faulting access: no request,
//   no stall, load rd_data=0, mem_fault=1 with that cword.
//  FSM IDLE/BUSY/DONE:
//   IDLE: access & ~fault_now -> BUSY; latch addr/we/be/wdata, dmem_req<=1, cnt<=0.
//         dmem_ack ignored in IDLE.
//   BUSY: dmem_ack -> dmem_req<=0, latch aligned load data, DONE.
//         else cnt++; cnt==DMEM_TIMEOUT-1 (TIMEOUT>0) -> dmem_req<=0, pending fault, load data 0, DONE.
//   DONE: ~stall -> IDLE (cword advances this edge); stall -> hold DONE, data held.
//  mem_stall = access & ~fault_now & (state != DONE).
//  Zero-wait memory (ack in first BUSY cycle): 2 stall cycles, advance on 3rd edge.
//  Store: SB be=1<<a[1:0], wdata={4{b}}; SH be=a[1]?4'b1100:4'b0011, wdata={2{h}}; SW 4'hF.
//  Load: select lane by a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW as is.
//  Output reg: if ~stall, mem_wb_cword<=cword (rd_data=load data if mem_read),
//   mem_fault<=fault_now|timeout; if stall, hold.
//  Non-memory cwords pass with one-cycle latency, never stall.
//  Reset mid-access: dmem_req drops next edge; late ack ignored in IDLE.
// TESTING
//  LW a=0x100, rdata=0xDEADBEEF, ack 1st BUSY cycle -> 2 stall cycles, rd_data=0xDEADBEEF, fault=0
//  SB a=0x103, rs2=0x000000A5 -> we=1, be=4'b1000, wdata=0xA5A5A5A5, addr=0x100
//  LB a=0x102, rdata=0x0080_0000 -> rd_data=0xFFFFFF80; LBU same -> 0x00000080
//  LH a=0x101 -> no dmem_req, mem_stall=0, mem_fault=1, rd_data=0
//  DMEM_TIMEOUT=4, ack never -> req low after 4 BUSY cycles, mem_fault=1, pipeline resumes
//  rst_n low in BUSY, ack next cycle -> dmem_req=0, state IDLE, outputs 0, ack ignored

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Runs loads/stores over a req/ack data-memory
// port, aligns and extends load data, and forwards the control word to WB.
//
// Control word layout (flat packed vector, CWORD_W >= 69):
//   [0]       mem_read
//   [1]       mem_write
//   [4:2]     funct3
//   [36:5]    rd_data  (effective address on entry, load result on exit)
//   [68:37]   rs2_data (store data)
//   [W-1:69]  other pipeline fields, passed through untouched
module mem_access #(
  parameter int DMEM_TIMEOUT = 64,
  parameter int CWORD_W      = 80
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [CWORD_W-1:0] ex_mem_cword,
  output logic [CWORD_W-1:0] mem_wb_cword,
  output logic               mem_stall,
  output logic               mem_fault,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [31:0]        dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_ack
);

  localparam int RD_LSB  = 5;
  localparam int RS2_LSB = 37;
  localparam int CNT_W   = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [31:0]        load_data_r;
  logic               tmo_r;

  logic               mem_read_s, mem_write_s, access_s;
  logic               misaligned_s, illegal_s, fault_now_s;
  logic [2:0]         funct3_s;
  logic [31:0]        addr_s, rs2_s;
  logic               start_s, ack_s, timeout_s;
  logic [CWORD_W-1:0] wb_next_s;

  // Byte enables for a store of the given size (funct3[1:0]) at byte offset lo.
  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   store_be = 4'b0001 << lo;
      2'b01:   store_be = lo[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane the access could hit.
  function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   store_wdata = {4{d[7:0]}};
      2'b01:   store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  // Select the addressed lane from a read word and sign/zero-extend it.
  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {lo, 3'b000};
    case (f3)
      3'b000:  load_align = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_align = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_align = {24'h000000, sh[7:0]};
      3'b101:  load_align = {16'h0000, sh[15:0]};
      default: load_align = sh;
    endcase
  endfunction

  // Decode the incoming control word and classify faulting accesses.
  always_comb begin
    mem_read_s   = ex_mem_cword[0];
    mem_write_s  = ex_mem_cword[1];
    funct3_s     = ex_mem_cword[4:2];
    addr_s       = ex_mem_cword[RD_LSB +: 32];
    rs2_s        = ex_mem_cword[RS2_LSB +: 32];
    access_s     = mem_read_s | mem_write_s;
    misaligned_s = ((funct3_s[1:0] == 2'b01) && addr_s[0]) ||
                   ((funct3_s[1:0] == 2'b10) && (addr_s[1:0] != 2'b00));
    illegal_s    = (funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111) ||
                   (mem_read_s & mem_write_s);
    fault_now_s  = access_s & (misaligned_s | illegal_s);
  end

  // Stall while a legal access has not yet reached DONE.
  assign mem_stall = access_s & ~fault_now_s & (state_r != ST_DONE);

  // Access FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Access FSM next-state and strobes.
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    ack_s     = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (access_s && !fault_now_s) begin
          state_s = ST_BUSY;
          start_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (dmem_ack) begin
          state_s = ST_DONE;
          ack_s   = 1'b1;
        end else if ((DMEM_TIMEOUT > 0) && (cnt_r == CNT_W'(DMEM_TIMEOUT - 1))) begin
          state_s   = ST_DONE;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (!stall) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Memory port, wait counter, load-data and timeout-flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0;
      dmem_be     <= 4'h0;
      dmem_wdata  <= 32'h0;
      cnt_r       <= '0;
      load_data_r <= 32'h0;
      tmo_r       <= 1'b0;
    end else if (start_s) begin
      dmem_req   <= 1'b1;
      dmem_we    <= mem_write_s;
      dmem_addr  <= {addr_s[31:2], 2'b00};
      dmem_be    <= mem_write_s ? store_be(funct3_s[1:0], addr_s[1:0]) : 4'hF;
      dmem_wdata <= mem_write_s ? store_wdata(funct3_s[1:0], rs2_s) : 32'h0;
      cnt_r      <= '0;
      tmo_r      <= 1'b0;
    end else if (ack_s) begin
      dmem_req    <= 1'b0;
      load_data_r <= load_align(funct3_s, addr_s[1:0], dmem_rdata);
    end else if (timeout_s) begin
      dmem_req    <= 1'b0;
      load_data_r <= 32'h0;
      tmo_r       <= 1'b1;
    end else if (state_r == ST_BUSY) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else if ((state_r == ST_DONE) && !stall) begin
      tmo_r <= 1'b0;
    end else begin
      tmo_r <= tmo_r;
    end
  end

  // Outgoing control word: loads carry the aligned result (zero on fault).
  always_comb begin
    wb_next_s = ex_mem_cword;
    wb_next_s[RD_LSB +: 32] = mem_read_s ? ((state_r == ST_DONE) ? load_data_r : 32'h0)
                                         : addr_s;
  end

  // MEM/WB output register, frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_wb_cword <= '0;
      mem_fault    <= 1'b0;
    end else if (!stall) begin
      mem_wb_cword <= wb_next_s;
      mem_fault    <= fault_now_s | ((state_r == ST_DONE) & tmo_r);
    end else begin
      mem_wb_cword <= mem_wb_cword;
      mem_fault    <= mem_fault;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized self-checking bench for mem_access, with a
// behavioural model of the stage and a responsive data memory.
module tb_mem_access;

  localparam int TMO = 4;
  localparam int CW  = 80;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ext_stall;
  logic          stall;
  logic [CW-1:0] ex_mem_cword;
  logic [CW-1:0] mem_wb_cword;
  logic          mem_stall, mem_fault;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]    dmem_be;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CW-1:0] prev_wb;
  logic          prev_fault;

  always #5 clk = ~clk;
  assign stall = mem_stall | ext_stall;

  mem_access #(.DMEM_TIMEOUT(TMO), .CWORD_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .ex_mem_cword(ex_mem_cword), .mem_wb_cword(mem_wb_cword),
    .mem_stall(mem_stall), .mem_fault(mem_fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk_cw(input bit r, input bit w, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] d,
                                          input logic [10:0] m);
    return {m, d, a, f3, w, r};
  endfunction

  // Reference value a load returns, from the lane rules.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
    logic [31:0] b, h, s;
    s = rdata >> (8 * (a % 4));
    b = s & 32'hFF;
    h = s & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  // Drive one control word; memory acks on BUSY cycle 'delay' (never if delay >= TMO);
  // 'hold' extra external stall cycles are applied once the stage stops stalling.
  task automatic issue(input logic [CW-1:0] cw, input int delay, input logic [31:0] rdata,
                       input int hold);
    bit r, w, acc, flt, tmo, finished;
    logic [2:0] f3;
    logic [31:0] a, d, exp_rd, exp_be, exp_wd;
    logic [CW-1:0] exp_wb;
    int stall_cnt, req_cnt, c, exp_stall, exp_req;
    r  = cw[0];
    w  = cw[1];
    f3 = cw[4:2];
    a  = cw[36:5];
    d  = cw[68:37];
    acc = r | w;
    flt = acc && ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (r && w) ||
                  ((f3 % 4 == 1) && (a % 2 != 0)) || ((f3 % 4 == 2) && (a % 4 != 0)));
    tmo = acc && !flt && (delay >= TMO);
    if (!acc || flt) begin
      exp_stall = 0; exp_req = 0;
    end else if (tmo) begin
      exp_stall = TMO + 1; exp_req = TMO;
    end else begin
      exp_stall = delay + 2; exp_req = delay + 1;
    end
    case (f3 % 4)
      0:       begin exp_be = 32'd1 << (a % 4); exp_wd = (d & 32'hFF) * 32'h01010101; end
      1:       begin exp_be = (a % 4 >= 2) ? 32'hC : 32'h3; exp_wd = (d & 32'hFFFF) * 32'h00010001; end
      default: begin exp_be = 32'hF; exp_wd = d; end
    endcase
    if (!w) exp_be = 32'hF;
    exp_rd = (flt || tmo) ? 32'h0 : ref_load(f3, a, rdata);
    exp_wb = cw;
    if (r) exp_wb[36:5] = exp_rd;

    ex_mem_cword = cw;
    stall_cnt = 0; req_cnt = 0; c = 0; finished = 1'b0;
    while (!finished && c < 40) begin
      #1;
      if (dmem_req) begin
        if (req_cnt == 0) begin
          check("req_addr", dmem_addr, a & 32'hFFFFFFFC);
          check("req_we", dmem_we, w);
          check("req_be", dmem_be, exp_be[3:0]);
          if (w) check("req_wdata", dmem_wdata, exp_wd);
        end
        dmem_ack   = (req_cnt == delay);
        dmem_rdata = (req_cnt == delay) ? rdata : $urandom;
        req_cnt++;
      end else begin
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
      if (mem_stall) begin
        stall_cnt++;
        @(negedge clk);
      end else begin
        finished = 1'b1;
      end
      c++;
    end
    if (!finished) check("stall_bound", 0, 1);
    check("stall_cycles", stall_cnt, exp_stall);
    check("req_cycles", req_cnt, exp_req);
    for (int k = 0; k < hold; k++) begin
      ext_stall = 1'b1;
      @(posedge clk);
      #1;
      check("hold_wb", mem_wb_cword, prev_wb);
      check("hold_fault", mem_fault, prev_fault);
      @(negedge clk);
      dmem_rdata = $urandom;
    end
    ext_stall = 1'b0;
    @(posedge clk);
    #1;
    check("wb_cword", mem_wb_cword, exp_wb);
    check("wb_fault", mem_fault, flt | tmo);
    prev_wb    = exp_wb;
    prev_fault = flt | tmo;
    @(negedge clk);
  endtask

  initial begin
    logic [CW-1:0] cw;
    logic [31:0] a;
    logic [2:0] f3;
    bit r, w;
    int sel;
    rst_n = 1'b0; ext_stall = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    ex_mem_cword = '0;
    prev_wb = '0; prev_fault = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_wb", mem_wb_cword, 0);
    check("rst_fault", mem_fault, 0);
    check("rst_req", dmem_req, 0);
    check("rst_port", {dmem_we, dmem_addr, dmem_be, dmem_wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    issue(mk_cw(1, 0, 3'd2, 32'h100, 32'h0, 11'h1), 0, 32'hDEADBEEF, 0);
    issue(mk_cw(0, 1, 3'd0, 32'h103, 32'hA5, 11'h2), 1, 32'h0, 1);
    issue(mk_cw(1, 0, 3'd0, 32'h102, 32'h0, 11'h3), 2, 32'h00800000, 0);
    issue(mk_cw(1, 0, 3'd4, 32'h102, 32'h0, 11'h4), 0, 32'h00800000, 2);
    issue(mk_cw(1, 0, 3'd1, 32'h101, 32'h0, 11'h5), 0, 32'h12345678, 0);
    issue(mk_cw(1, 0, 3'd2, 32'h200, 32'h0, 11'h6), 99, 32'h12345678, 0);
    issue(mk_cw(0, 0, 3'd2, 32'hCAFE0001, 32'h5, 11'h7), 0, 32'h0, 1);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      r = (sel >= 2 && sel <= 5) || sel == 9;
      w = (sel >= 6);
      if (sel == 9 || $urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (r) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end else f3 = 3'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      cw = mk_cw(r, w, f3, a, $urandom, 11'($urandom));
      issue(cw, $urandom_range(0, 5), $urandom, $urandom_range(0, 2));
    end

    // Reset while an access is outstanding; a late ack must be ignored.
    ex_mem_cword = mk_cw(1, 0, 3'd2, 32'h300, 32'h0, 11'h0);
    dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    check("busy_req", dmem_req, 1);
    rst_n = 1'b0;
    ex_mem_cword = '0;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    #1;
    check("rst_busy_req", dmem_req, 0);
    check("rst_busy_wb", mem_wb_cword, 0);
    check("rst_busy_fault", mem_fault, 0);
    check("rst_busy_port", {dmem_we, dmem_addr, dmem_be, dmem_wdata}, 0);
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check("late_ack_req", dmem_req, 0);
    check("late_ack_stall", mem_stall, 0);
    check("late_ack_wb", mem_wb_cword, 0);
    prev_wb = '0; prev_fault = 1'b0;
    @(negedge clk);
    issue(mk_cw(1, 0, 3'd5, 32'h402, 32'h0, 11'h9), 1, 32'h8001FFFF, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
